// File: rtl/conv_pkg.sv
// Shared types and helpers for the row-streaming convolution layer.
//   - Default geometry plus the derived output width and tap count for it.
//   - state_t   : layer controller states.
//   - tap_decode: flat tap index -> (channel, filter row, filter column).
//   - sat_shift : accumulator -> FRAC shift, saturate to dw bits, optional ReLU.
package conv_pkg;

    localparam int unsigned DEF_D = 1;
    localparam int unsigned DEF_W = 64;
    localparam int unsigned DEF_F = 3;
    localparam int unsigned OUT_W = DEF_W - DEF_F + 1;
    localparam int unsigned TAPS  = DEF_D * DEF_F * DEF_F;

    typedef enum logic [1:0] {
        S_FILL    = 2'd0,
        S_COMPUTE = 2'd1,
        S_OUTPUT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [15:0] d;
        logic [15:0] fr;
        logic [15:0] fc;
    } tap_t;

    // t = (d*f + fr)*f + fc
    function automatic tap_t tap_decode(input int unsigned t, input int unsigned f);
        tap_t r;
        r.fc = 16'(t % f);
        r.fr = 16'((t / f) % f);
        r.d  = 16'(t / (f * f));
        return r;
    endfunction

    // The result is returned at 64 bits; callers keep the low dw bits.
    function automatic logic signed [63:0] sat_shift(input logic signed [63:0] acc,
                                                     input int unsigned       frac,
                                                     input int unsigned       dw,
                                                     input logic              relu);
        logic signed [63:0] v;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        v  = acc >>> frac;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (v > hi) begin
            v = hi;
        end else if (v < lo) begin
            v = lo;
        end
        if (relu && (v < 64'sd0)) begin
            v = 64'sd0;
        end
        return v;
    endfunction

endpackage

// File: rtl/conv_layer_stream_mac_lane.sv
// conv_mac_lane: accumulator for one output pixel of one filter.
//   clk, reset       : clock, asynchronous active-high reset
//   i_en, i_first    : accumulate this cycle; load instead of add on the first tap
//   i_pix, i_wgt     : signed pixel and weight for the current tap
//   o_res_c          : shifted, saturated (and optionally rectified) result, combinational
module conv_mac_lane
    import conv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ACC_WIDTH  = 40,
    parameter int unsigned FRAC       = 8,
    parameter int unsigned RELU       = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_en,
    input  logic                         i_first,
    input  logic signed [DATA_WIDTH-1:0] i_pix,
    input  logic signed [DATA_WIDTH-1:0] i_wgt,
    output logic signed [DATA_WIDTH-1:0] o_res_c
);

    localparam int unsigned PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0]        w_prod;
    logic signed [ACC_WIDTH-1:0] w_prod_ext;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic signed [63:0]          w_sat;

    assign w_prod     = PW'(i_pix) * PW'(i_wgt);
    assign w_prod_ext = ACC_WIDTH'(w_prod);

    // Tap accumulation; the first tap overwrites the previous row's sum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= i_first ? w_prod_ext : r_acc + w_prod_ext;
        end
    end

    assign w_sat   = sat_shift(64'(r_acc), FRAC, DATA_WIDTH, RELU != 0);
    assign o_res_c = DATA_WIDTH'(w_sat);

endmodule

// File: rtl/conv_layer_stream.sv
// conv_layer_stream: row-streaming K-filter FxF convolution (stride 1, no padding).
//   clk, reset                  : clock, asynchronous active-high reset
//   row_in/row_valid/row_last   : input row handshake, row_ready back-pressures
//   filters                     : K*D*F*F signed weights, stable while busy
//   out_row/out_valid/out_last  : one row per filter per window, held until out_ready
//   busy                        : computing, presenting, or a partial window buffered
module conv_layer_stream
    import conv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ACC_WIDTH  = 40,
    parameter int unsigned D          = DEF_D,
    parameter int unsigned W          = DEF_W,
    parameter int unsigned F          = DEF_F,
    parameter int unsigned K          = 2,
    parameter int unsigned FRAC       = 8,
    parameter int unsigned RELU       = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [D*W*DATA_WIDTH-1:0]            row_in,
    input  logic                                 row_valid,
    input  logic                                 row_last,
    output logic                                 row_ready,
    input  logic [K*D*F*F*DATA_WIDTH-1:0]        filters,
    output logic [K*(W-F+1)*DATA_WIDTH-1:0]      out_row,
    output logic                                 out_valid,
    output logic                                 out_last,
    input  logic                                 out_ready,
    output logic                                 busy
);

    localparam int unsigned N_OUT  = W - F + 1;
    localparam int unsigned N_TAPS = D * F * F;
    localparam int unsigned ROW_W  = D * W * DATA_WIDTH;
    localparam int unsigned TW     = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam int unsigned HW     = (F > 1) ? $clog2(F) : 1;
    localparam int unsigned LW     = $clog2(F + 1);
    localparam int unsigned IW     = $clog2(ROW_W);
    localparam int unsigned FIW    = $clog2(K * N_TAPS * DATA_WIDTH);

    state_t                            r_state;
    logic [TW-1:0]                     r_tap;
    logic [HW-1:0]                     r_head;
    logic [LW-1:0]                     r_loaded;
    logic                              r_frame_last;
    logic                              r_err_short;
    logic                              r_row_ready;
    logic                              r_out_valid;
    logic                              r_out_last;
    logic                              r_busy;
    logic [K*N_OUT*DATA_WIDTH-1:0]     r_out_row;
    logic [ROW_W-1:0]                  r_lbuf [F];

    logic                              w_accept;
    logic                              w_mac_en;
    tap_t                              w_dec;
    logic [HW-1:0]                     w_slot;
    logic [ROW_W-1:0]                  w_row;
    logic signed [DATA_WIDTH-1:0]      w_pix [N_OUT];
    logic signed [DATA_WIDTH-1:0]      w_wgt [K];
    logic [K*N_OUT*DATA_WIDTH-1:0]     w_res;

    assign w_accept = row_valid & r_row_ready;
    assign w_mac_en = (r_state == S_COMPUTE);
    assign w_dec    = tap_decode(32'(r_tap), F);

    // Ring buffer: r_head is the oldest slot once F rows are held.
    always_comb begin
        int unsigned s;
        s = 32'(r_head) + 32'(w_dec.fr);
        if (s >= F) begin
            s = s - F;
        end
        w_slot = HW'(s);
    end

    assign w_row = r_lbuf[w_slot];

    // Per-lane pixel at column x+fc; weight per filter for the current tap.
    always_comb begin
        for (int x = 0; x < N_OUT; x++) begin
            w_pix[x] = w_row[IW'((32'(w_dec.d) * W + 32'(x) + 32'(w_dec.fc)) * DATA_WIDTH) +: DATA_WIDTH];
        end
        for (int k = 0; k < K; k++) begin
            w_wgt[k] = filters[FIW'((32'(k) * N_TAPS + 32'(r_tap)) * DATA_WIDTH) +: DATA_WIDTH];
        end
    end

    for (genvar gk = 0; gk < K; gk++) begin : g_k
        for (genvar gx = 0; gx < N_OUT; gx++) begin : g_x
            conv_mac_lane #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH),
                .FRAC       (FRAC),
                .RELU       (RELU)
            ) u_lane (
                .clk     (clk),
                .reset   (reset),
                .i_en    (w_mac_en),
                .i_first (r_tap == '0),
                .i_pix   (w_pix[gx]),
                .i_wgt   (w_wgt[gk]),
                .o_res_c (w_res[(gk*N_OUT+gx)*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    end

    // Row storage is data only; validity is tracked by r_loaded.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lbuf[r_head] <= row_in;
        end
    end

    // Controller: fill window, run taps, present result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_FILL;
            r_tap        <= '0;
            r_head       <= '0;
            r_loaded     <= '0;
            r_frame_last <= 1'b0;
            r_err_short  <= 1'b0;
            r_row_ready  <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_busy       <= 1'b0;
            r_out_row    <= '0;
        end else begin
            r_err_short <= 1'b0;
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        r_head       <= (r_head == HW'(F - 1)) ? '0 : r_head + 1'b1;
                        r_frame_last <= row_last;
                        if (r_loaded >= LW'(F - 1)) begin
                            r_loaded    <= LW'(F);
                            r_state     <= S_COMPUTE;
                            r_row_ready <= 1'b0;
                            r_tap       <= '0;
                            r_busy      <= 1'b1;
                        end else if (row_last) begin
                            r_loaded    <= '0;
                            r_err_short <= 1'b1;
                            r_busy      <= 1'b0;
                        end else begin
                            r_loaded    <= r_loaded + 1'b1;
                            r_busy      <= 1'b1;
                        end
                    end
                end
                S_COMPUTE: begin
                    if (r_tap == TW'(N_TAPS - 1)) begin
                        r_state <= S_OUTPUT;
                    end else begin
                        r_tap <= r_tap + 1'b1;
                    end
                end
                S_OUTPUT: begin
                    if (!r_out_valid) begin
                        r_out_row   <= w_res;
                        r_out_valid <= 1'b1;
                        r_out_last  <= r_frame_last;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_loaded    <= r_frame_last ? '0 : LW'(F);
                        r_busy      <= ~r_frame_last;
                        r_row_ready <= 1'b1;
                        r_state     <= S_FILL;
                    end
                end
                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

    // A short frame must leave the window empty.
    always_ff @(posedge clk) begin
        if (!reset && r_err_short) begin
            assert (r_loaded == '0);
        end
    end

    assign row_ready = r_row_ready;
    assign out_row   = r_out_row;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = r_busy;

endmodule

// File: tb/tb_conv_layer_stream.sv
module tb_conv_layer_stream;

    localparam int unsigned DW   = 16;
    localparam int unsigned D    = 1;
    localparam int unsigned W    = 5;
    localparam int unsigned F    = 3;
    localparam int unsigned K    = 2;
    localparam int unsigned FRAC = 0;
    localparam int unsigned OW   = W - F + 1;
    localparam int unsigned TAPS = D * F * F;
    localparam int unsigned RW   = D * W * DW;
    localparam int unsigned FW   = K * TAPS * DW;
    localparam int unsigned OVW  = K * OW * DW;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [RW-1:0]   row_in = '0;
    logic            row_valid = 1'b0;
    logic            row_last = 1'b0;
    logic [FW-1:0]   filters = '0;
    logic            out_ready;
    logic            fix_ready = 1'b1;
    logic            rnd_phase = 1'b0;
    logic            rnd_bit = 1'b1;

    logic            row_ready, row_ready_r;
    logic [OVW-1:0]  out_row, out_row_r;
    logic            out_valid, out_valid_r;
    logic            out_last, out_last_r;
    logic            busy, busy_r;

    assign out_ready = rnd_phase ? rnd_bit : fix_ready;

    conv_layer_stream #(.DATA_WIDTH(DW), .ACC_WIDTH(40), .D(D), .W(W), .F(F), .K(K),
                        .FRAC(FRAC), .RELU(0)) dut (
        .clk(clk), .reset(reset), .row_in(row_in), .row_valid(row_valid), .row_last(row_last),
        .row_ready(row_ready), .filters(filters), .out_row(out_row), .out_valid(out_valid),
        .out_last(out_last), .out_ready(out_ready), .busy(busy));

    conv_layer_stream #(.DATA_WIDTH(DW), .ACC_WIDTH(40), .D(D), .W(W), .F(F), .K(K),
                        .FRAC(FRAC), .RELU(1)) dut_r (
        .clk(clk), .reset(reset), .row_in(row_in), .row_valid(row_valid), .row_last(row_last),
        .row_ready(row_ready_r), .filters(filters), .out_row(out_row_r), .out_valid(out_valid_r),
        .out_last(out_last_r), .out_ready(out_ready), .busy(busy_r));

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1;
        rnd_bit = ($urandom_range(0, 3) != 0);
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Reference model: image rows and filters as plain integer arrays.
    int img [8][W];
    int wt  [K][F][F];

    function automatic int ref_pix(int k, int x, int r0, bit relu);
        longint s = 0;
        for (int fr = 0; fr < F; fr++)
            for (int fc = 0; fc < F; fc++)
                s += longint'(img[r0+fr][x+fc]) * longint'(wt[k][fr][fc]);
        s = s >>> FRAC;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        if (relu && s < 0) s = 0;
        return int'(s);
    endfunction

    function automatic logic [OVW-1:0] model_row(int r0, bit relu);
        logic [OVW-1:0] v = '0;
        for (int k = 0; k < K; k++)
            for (int x = 0; x < OW; x++)
                v[(k*OW+x)*DW +: DW] = 16'(ref_pix(k, x, r0, relu));
        return v;
    endfunction

    function automatic logic [RW-1:0] row_vec(int r);
        logic [RW-1:0] v = '0;
        for (int x = 0; x < W; x++) v[x*DW +: DW] = 16'(img[r][x]);
        return v;
    endfunction

    function automatic logic [FW-1:0] filt_vec();
        logic [FW-1:0] v = '0;
        for (int k = 0; k < K; k++)
            for (int fr = 0; fr < F; fr++)
                for (int fc = 0; fc < F; fc++)
                    v[(k*TAPS + fr*F + fc)*DW +: DW] = 16'(wt[k][fr][fc]);
        return v;
    endfunction

    function automatic logic [OVW-1:0] basic_vec(int b0, int b1);
        logic [OVW-1:0] v = '0;
        for (int x = 0; x < OW; x++) begin
            v[x*DW +: DW]      = 16'(b0 + 9*x);
            v[(OW+x)*DW +: DW] = 16'(b1 + x);
        end
        return v;
    endfunction

    function automatic logic [OVW-1:0] rep(logic [15:0] p);
        logic [OVW-1:0] v = '0;
        for (int j = 0; j < K*OW; j++) v[j*DW +: DW] = p;
        return v;
    endfunction

    typedef struct {
        logic [OVW-1:0] v;
        logic [OVW-1:0] vr;
        logic           last;
    } exp_t;
    exp_t q[$];

    typedef struct {
        logic [15:0] pix;
        logic [15:0] wgt;
        logic [15:0] exp_n;
        logic [15:0] exp_r;
    } sat_vec_t;
    sat_vec_t tab [7];

    // Scoreboard: every output handshake must match the next expected row.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out got=%h exp=none", out_row);
            end else begin
                e = q.pop_front();
                chk("out_row", 128'(out_row), 128'(e.v));
                chk("out_row_relu", 128'(out_row_r), 128'(e.vr));
                chk("out_last", 128'(out_last), 128'(e.last));
                chk("relu_sync", 128'({out_valid_r, out_last_r}), 128'({1'b1, e.last}));
            end
        end
    end

    task automatic send_row(input logic [RW-1:0] d, input logic last);
        int n = 0;
        row_in = d; row_valid = 1'b1; row_last = last;
        while (!row_ready && n < 300) begin
            @(posedge clk); #1; n++;
        end
        if (!row_ready) begin
            total++; bad++;
            $display("FAIL row_ready_timeout got=0 exp=1");
        end
        @(posedge clk); #1;
        row_valid = 1'b0; row_last = 1'b0;
    endtask

    task automatic send_frame(input int n);
        for (int r = 0; r < n; r++) send_row(row_vec(r), r == n - 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || out_valid || q.size() != 0) && n < 600) begin
            @(posedge clk); #1; n++;
        end
        chk("idle", 128'({busy, out_valid, q.size() != 0}), 128'(0));
    endtask

    task automatic set_basic();
        for (int r = 0; r < 8; r++)
            for (int x = 0; x < W; x++) img[r][x] = 10*r + x;
        for (int k = 0; k < K; k++)
            for (int fr = 0; fr < F; fr++)
                for (int fc = 0; fc < F; fc++)
                    wt[k][fr][fc] = (k == 0) ? 1 : ((fr == 1 && fc == 1) ? 1 : 0);
        filters = filt_vec();
    endtask

    task automatic watch_silent(input string nm, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk(nm, 128'(seen), 128'(0));
    endtask

    initial begin
        int n;
        tab[0] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        tab[1] = '{16'h7FFF, 16'h8001, 16'h8000, 16'h0000};
        tab[2] = '{16'h0001, 16'h0001, 16'h0009, 16'h0009};
        tab[3] = '{16'hFFFF, 16'h0001, 16'hFFF7, 16'h0000};
        tab[4] = '{16'h0002, 16'hFFFD, 16'hFFCA, 16'h0000};
        tab[5] = '{16'h0100, 16'h0080, 16'h7FFF, 16'h7FFF};
        tab[6] = '{16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_ctl", 128'({row_ready, out_valid, out_last, busy, row_ready_r, busy_r}),
            128'(6'b100010));
        chk("reset_row", 128'(out_row), 128'(0));

        // Basic 3-row frame with latency measurement.
        set_basic();
        q.push_back('{basic_vec(99, 11), basic_vec(99, 11), 1'b1});
        send_row(row_vec(0), 1'b0);
        chk("busy_partial", 128'(busy), 128'(1));
        send_row(row_vec(1), 1'b0);
        send_row(row_vec(2), 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", 128'(n), 128'(TAPS + 1));
        wait_idle();

        // Sliding window over a 4-row frame.
        q.push_back('{basic_vec(99, 11), basic_vec(99, 11), 1'b0});
        q.push_back('{basic_vec(189, 21), basic_vec(189, 21), 1'b1});
        send_frame(4);
        wait_idle();

        // Back-pressure: result held for 5 stalled cycles.
        fix_ready = 1'b0;
        q.push_back('{basic_vec(99, 11), basic_vec(99, 11), 1'b1});
        send_frame(3);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("stall_ctl", 128'({out_valid, out_last, row_ready}), 128'(3'b110));
            chk("stall_row", 128'(out_row), 128'(basic_vec(99, 11)));
            @(posedge clk); #1;
        end
        fix_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_1cycle", 128'(out_valid), 128'(0));
        wait_idle();

        // Saturation / ReLU table.
        for (int i = 0; i < 7; i++) begin
            for (int r = 0; r < F; r++)
                for (int x = 0; x < W; x++) img[r][x] = int'($signed(tab[i].pix));
            for (int k = 0; k < K; k++)
                for (int fr = 0; fr < F; fr++)
                    for (int fc = 0; fc < F; fc++) wt[k][fr][fc] = int'($signed(tab[i].wgt));
            filters = filt_vec();
            q.push_back('{rep(tab[i].exp_n), rep(tab[i].exp_r), 1'b1});
            send_frame(3);
            wait_idle();
        end

        // Short frame produces nothing; the next frame is unaffected.
        set_basic();
        send_frame(2);
        watch_silent("short_no_out", 20);
        chk("short_busy", 128'(busy), 128'(0));
        q.push_back('{basic_vec(99, 11), basic_vec(99, 11), 1'b1});
        send_frame(3);
        wait_idle();

        // Reset during COMPUTE at tap 4.
        send_frame(3);
        repeat (4) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        chk("midreset_ctl", 128'({row_ready, out_valid, out_last, busy}), 128'(4'b1000));
        chk("midreset_row", 128'(out_row), 128'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        watch_silent("midreset_no_out", 20);
        q.push_back('{basic_vec(99, 11), basic_vec(99, 11), 1'b1});
        send_frame(3);
        wait_idle();

        // Random frames against the model, with random consumer stalls.
        rnd_phase = 1'b1;
        for (int f = 0; f < 8; f++) begin
            int nr, amp, wamp;
            nr   = int'($urandom_range(3, 7));
            amp  = (f % 2 == 0) ? 300 : 30000;
            wamp = (f % 2 == 0) ? 20 : 3000;
            for (int r = 0; r < nr; r++)
                for (int x = 0; x < W; x++)
                    img[r][x] = int'($urandom_range(0, 2*amp)) - amp;
            for (int k = 0; k < K; k++)
                for (int fr = 0; fr < F; fr++)
                    for (int fc = 0; fc < F; fc++)
                        wt[k][fr][fc] = int'($urandom_range(0, 2*wamp)) - wamp;
            filters = filt_vec();
            for (int r0 = 0; r0 <= nr - int'(F); r0++)
                q.push_back('{model_row(r0, 1'b0), model_row(r0, 1'b1), r0 == nr - int'(F)});
            send_frame(nr);
            wait_idle();
        end
        rnd_phase = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
